aes_inverse_cipher: RTL and testbench

Iterative AES-128 decryption engine: accepts one 128-bit ciphertext block, runs the FIPS-197 inverse cipher one round per clock, and presents the 128-bit plaintext. It is the decrypt-side counterpart of the encrypt round datapath. It instantiates the existing ShiftRowsInverse, SubBytesInverse, MixColumnsInverse and AddRoundKey stages around a single state register. Round keys come from an external, already-expanded key store.

---
 rtl/aes_inverse_cipher.sv | 184 ++++++++++++++++++
 tb/tb_aes_inverse_cipher.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inverse_cipher.sv
//==============================================================================
// aes_inverse_cipher : iterative AES-128 decryption, one inverse round per clock
// Rev 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ShiftRowsInverse (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   // Row r rotates right by r columns; byte n sits at [127-8n -: 8], n = r + 4c.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign o_state[127-8*(r+4*c) -: 8] = i_state[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
   end
endmodule

module SubBytesInverse (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x3, x7, x15, x31, x63, x127;
      x3   = gf_mul(gf_mul(a, a), a);
      x7   = gf_mul(gf_mul(x3, x3), a);
      x15  = gf_mul(gf_mul(x7, x7), a);
      x31  = gf_mul(gf_mul(x15, x15), a);
      x63  = gf_mul(gf_mul(x31, x31), a);
      x127 = gf_mul(gf_mul(x63, x63), a);
      return gf_mul(x127, x127);
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] t;
      t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

   for (genvar n = 0; n < 16; n++) begin : g_byte
      assign o_state[127-8*n -: 8] = inv_sbox(i_state[127-8*n -: 8]);
   end
endmodule

module MixColumnsInverse (
   input  logic [127:0] i_state,
   output logic [127:0] o_state
);
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Coefficient row {0e,0b,0d,09}, rotated per output row.
   function automatic logic [7:0] mul_coef(input logic [7:0] a, input logic [1:0] idx);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (idx)
         2'd0:    return x8 ^ x4 ^ x2;
         2'd1:    return x8 ^ x2 ^ a;
         2'd2:    return x8 ^ x4 ^ a;
         default: return x8 ^ a;
      endcase
   endfunction

   function automatic logic [7:0] inv_mix_byte(input logic [31:0] col, input int r);
      logic [7:0] acc;
      acc = '0;
      for (int k = 0; k < 4; k++) acc = acc ^ mul_coef(col[31-8*k -: 8], 2'(k + 4 - r));
      return acc;
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign o_state[127-8*(r+4*c) -: 8] = inv_mix_byte(i_state[127-32*c -: 32], r);
      end
   end
endmodule

module AddRoundKey (
   input  logic [127:0] i_state,
   input  logic [127:0] i_round_key,
   output logic [127:0] o_state
);
   assign o_state = i_state ^ i_round_key;
endmodule

module aes_inverse_cipher (
   input  logic         clock,
   input  logic         reset,
   input  logic         inValid,
   output logic         inReady,
   input  logic [127:0] inData,
   output logic [3:0]   keyIndex,
   input  logic [127:0] roundKey,
   output logic         outValid,
   input  logic         outReady,
   output logic [127:0] outData
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] isr_out, isb_out, ark_out, imc_out, init_ark;

   ShiftRowsInverse  u_isr  (.i_state(state_q), .o_state(isr_out));
   SubBytesInverse   u_isb  (.i_state(isr_out), .o_state(isb_out));
   AddRoundKey       u_ark  (.i_state(isb_out), .i_round_key(roundKey), .o_state(ark_out));
   MixColumnsInverse u_imc  (.i_state(ark_out), .o_state(imc_out));
   AddRoundKey       u_ark0 (.i_state(inData),  .i_round_key(roundKey), .o_state(init_ark));

   always_ff @(posedge clock) begin
      if (reset) begin
         fsm_q   <= ST_IDLE;
         round_q <= 4'd9;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
      end
   end

   // Handshake flags and keyIndex decode only from registered state.
   always_comb begin
      fsm_d    = fsm_q;
      round_d  = round_q;
      state_d  = state_q;
      inReady  = 1'b0;
      outValid = 1'b0;
      keyIndex = 4'd10;
      case (fsm_q)
         ST_IDLE: begin
            inReady = 1'b1;
            if (inValid) begin
               state_d = init_ark;
               round_d = 4'd9;
               fsm_d   = ST_ROUND;
            end
         end
         ST_ROUND: begin
            keyIndex = round_q;
            state_d  = imc_out;
            if (round_q == 4'd1) fsm_d = ST_FINAL;
            else                 round_d = round_q - 4'd1;
         end
         ST_FINAL: begin
            keyIndex = 4'd0;
            state_d  = ark_out;
            fsm_d    = ST_DONE;
         end
         ST_DONE: begin
            outValid = 1'b1;
            if (outReady) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   assign outData = state_q;
endmodule

`default_nettype wire

// File: tb/tb_aes_inverse_cipher.sv
//==============================================================================
// tb_aes_inverse_cipher : scoreboard bench with FIPS-197 known-answer vectors
// Rev 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_inverse_cipher;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         inValid = 1'b0;
   logic         outReady = 1'b0;
   logic         key_sel = 1'b0;
   logic [127:0] inData = '0;
   logic [127:0] exp_next = '0;
   logic         inReady, outValid;
   logic [3:0]   keyIndex;
   logic [127:0] roundKey, outData;

   logic [127:0] rk_b [0:10];
   logic [127:0] rk_c [0:10];

   typedef struct packed {
      logic [127:0] pt;
      logic [31:0]  acc_edge;
   } exp_t;
   exp_t sb[$];

   int   n_vec = 0, n_err = 0, n_acc = 0, edge_cnt = 0, acc_prev = 0, acc_last = 0;
   logic ov_prev = 1'b0;

   aes_inverse_cipher dut (
      .clock(clock), .reset(reset),
      .inValid(inValid), .inReady(inReady), .inData(inData),
      .keyIndex(keyIndex), .roundKey(roundKey),
      .outValid(outValid), .outReady(outReady), .outData(outData)
   );

   always #5 clock = ~clock;

   always_comb begin
      roundKey = '0;
      if (keyIndex <= 4'd10) roundKey = key_sel ? rk_c[keyIndex] : rk_b[keyIndex];
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv, p;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
         p = 8'(c);
         if (gf_mul(a, p) == 8'h01) inv = p;
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   task automatic expand_key(input logic [127:0] key, input logic sel);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) begin
         if (sel) rk_c[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else     rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   // Scoreboard: push on accepted input, pop and compare on output handshake.
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         sb.delete();
      end else begin
         if (outValid && !ov_prev) begin
            check_eq("out_has_pending_block", 128'(sb.size() > 0), 128'd1);
            if (sb.size() > 0) check_eq("latency", 128'(edge_cnt - 1 - int'(sb[0].acc_edge)), 128'd10);
         end
         if (outValid && outReady) begin
            check_eq("pop_has_pending_block", 128'(sb.size() > 0), 128'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check_eq("plaintext", outData, e.pt);
            end
         end
         if (inValid && inReady) begin
            sb.push_back('{pt: exp_next, acc_edge: 32'(edge_cnt)});
            n_acc++;
            acc_prev = acc_last;
            acc_last = edge_cnt;
         end
      end
      ov_prev = outValid;
   end

   task automatic drive(input logic [127:0] ct, input logic [127:0] pt);
      inData   = ct;
      exp_next = pt;
      inValid  = 1'b1;
   endtask

   task automatic wait_accept(input string tag);
      int   base;
      logic got;
      base = n_acc;
      got  = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clock); #1;
         if (n_acc != base) got = 1'b1;
      end
      check_eq(tag, 128'(got), 128'd1);
   endtask

   task automatic wait_out(input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clock); #1;
         if (outValid) got = 1'b1;
      end
      check_eq(tag, 128'(got), 128'd1);
   endtask

   task automatic wait_drained(input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock); #1;
         if (sb.size() == 0 && inReady && !outValid) got = 1'b1;
      end
      check_eq(tag, 128'(got), 128'd1);
   endtask

   initial begin
      logic saw_ov;
      expand_key(KEY_B, 1'b0);
      expand_key(KEY_C, 1'b1);
      repeat (2) @(posedge clock);
      @(negedge clock); #1;
      check_eq("rst_inReady",  128'(inReady),  128'd1);
      check_eq("rst_outValid", 128'(outValid), 128'd0);
      check_eq("rst_outData",  outData,        128'd0);
      check_eq("rst_keyIndex", 128'(keyIndex), 128'd10);
      check_eq("key_store_rk10", rk_b[10], RK10_B);
      @(posedge clock); #1;
      reset = 1'b0;

      // App. B with keyIndex walk
      outReady = 1'b1;
      key_sel  = 1'b0;
      drive(CT_B, PT_B);
      wait_accept("t1_accept");
      check_eq("t1_key_idle", 128'(keyIndex), 128'd10);
      @(posedge clock); #1;
      inValid = 1'b0;
      for (int i = 9; i >= 0; i--) begin
         @(negedge clock); #1;
         check_eq($sformatf("t1_keyIndex_%0d", i), 128'(keyIndex), 128'(i));
      end
      wait_drained("t1_drain");

      // App. C.1
      @(posedge clock); #1;
      key_sel = 1'b1;
      drive(CT_C, PT_C);
      wait_accept("t2_accept");
      @(posedge clock); #1;
      inValid = 1'b0;
      wait_drained("t2_drain");

      // Backpressure with ignored input pulses
      @(posedge clock); #1;
      key_sel  = 1'b0;
      outReady = 1'b0;
      drive(CT_B, PT_B);
      wait_accept("t3_accept");
      @(posedge clock); #1;
      inValid = 1'b0;
      wait_out("t3_outValid");
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         inValid  = (i % 2 == 0);
         inData   = {$urandom(), $urandom(), $urandom(), $urandom()};
         exp_next = '1;
         @(negedge clock); #1;
         check_eq("t3_hold_outData",  outData,         PT_B);
         check_eq("t3_hold_inReady",  128'(inReady),  128'd0);
         check_eq("t3_hold_outValid", 128'(outValid), 128'd1);
      end
      @(posedge clock); #1;
      inValid  = 1'b0;
      outReady = 1'b1;
      @(negedge clock); #1;
      check_eq("t3_release_still_done", 128'(inReady), 128'd0);
      @(negedge clock); #1;
      check_eq("t3_idle_inReady",  128'(inReady),  128'd1);
      check_eq("t3_idle_outValid", 128'(outValid), 128'd0);

      // Back-to-back: B then C.1, inValid and outReady held high
      @(posedge clock); #1;
      key_sel = 1'b0;
      drive(CT_B, PT_B);
      wait_accept("t4_accept_b");
      @(posedge clock); #1;
      inData   = CT_C;
      exp_next = PT_C;
      wait_out("t4_outValid_b");
      key_sel = 1'b1;
      wait_accept("t4_accept_c");
      @(posedge clock); #1;
      inValid = 1'b0;
      check_eq("t4_accept_spacing", 128'(acc_last - acc_prev), 128'd12);
      wait_drained("t4_drain");

      // Reset mid-block, then a clean App. B block
      @(posedge clock); #1;
      key_sel = 1'b0;
      drive(CT_B, PT_B);
      wait_accept("t5_accept");
      @(posedge clock); #1;
      inValid = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock); #1;
      check_eq("t5_rst_outValid", 128'(outValid), 128'd0);
      check_eq("t5_rst_inReady",  128'(inReady),  128'd1);
      check_eq("t5_rst_keyIndex", 128'(keyIndex), 128'd10);
      saw_ov = 1'b0;
      repeat (15) begin
         @(negedge clock); #1;
         if (outValid) saw_ov = 1'b1;
      end
      check_eq("t5_no_output", 128'(saw_ov), 128'd0);
      @(posedge clock); #1;
      drive(CT_B, PT_B);
      wait_accept("t5_accept2");
      @(posedge clock); #1;
      inValid = 1'b0;
      wait_drained("t5_drain");

      check_eq("accept_count", 128'(n_acc), 128'd7);
      check_eq("scoreboard_empty", 128'(sb.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

`default_nettype wire
